// File: rtl/shared_dout_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shared_dout_arbiter_if                                                   |
// | Request/data/grant bundle between requesters and the shared register.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface shared_dout_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 4
);
  logic [NREQ-1:0]    REQ;
  logic [NREQ*DW-1:0] DIN;
  logic [NREQ-1:0]    GNT;
  logic [DW-1:0]      DOUT;
  logic               SELOUT;
  logic               BUSY;

  modport master (output REQ, DIN, input GNT, DOUT, SELOUT, BUSY);
  modport slave  (input REQ, DIN, output GNT, DOUT, SELOUT, BUSY);
endinterface
`default_nettype wire

// File: rtl/shared_dout_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shared_dout_arbiter                                                      |
// | Shared DW-bit register loaded by NREQ requesters via req/grant; counts  |
// | when idle. ARB_FIXED_PRIO_EN selects fixed priority instead of RR.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module shared_dout_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 4,
  parameter int HOLD_MAX = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  shared_dout_arbiter_if.slave bus
);

  localparam int              c_PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]      c_HOLD_LAST = 4'(HOLD_MAX - 1);
  localparam logic [c_PW-1:0] c_PTR_RST   = c_PW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt,   w_gnt_nxt;
  logic [DW-1:0]   r_dout,  w_dout_nxt;
  logic            r_sel,   w_sel_nxt;
  logic [3:0]      r_hold,  w_hold_nxt;
  logic [c_PW-1:0] r_ptr,   w_ptr_nxt;
  logic [c_PW-1:0] r_gidx,  w_gidx_nxt;

  logic [c_PW-1:0] w_lo, w_hi, w_winner;
  logic            w_hi_ok;
  logic            w_req_g;
  logic [DW-1:0]   w_din_g;

  // w_lo: lowest requesting index; w_hi: lowest requesting index above the pointer
  always_comb begin
    w_lo    = '0;
    w_hi    = '0;
    w_hi_ok = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.REQ[i]) begin
        w_lo = c_PW'(i);
        if (c_PW'(i) > r_ptr) begin
          w_hi    = c_PW'(i);
          w_hi_ok = 1'b1;
        end
      end
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign w_winner = w_lo;
`else
  assign w_winner = w_hi_ok ? w_hi : w_lo;
`endif

  always_comb begin
    w_req_g = 1'b0;
    w_din_g = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gidx == c_PW'(i)) begin
        w_req_g = bus.REQ[i];
        w_din_g = bus.DIN[i*DW +: DW];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_dout_nxt  = r_dout + DW'(1);
    w_sel_nxt   = 1'b0;
    w_hold_nxt  = r_hold;
    w_ptr_nxt   = r_ptr;
    w_gidx_nxt  = r_gidx;
    case (r_state)
      S_GRANT: begin
        if (w_req_g) begin
          w_dout_nxt = w_din_g;
          w_sel_nxt  = 1'b1;
          w_hold_nxt = r_hold + 4'd1;
          if (r_hold == c_HOLD_LAST) begin
            w_gnt_nxt   = '0;
            w_state_nxt = S_RELEASE;
          end
        end else begin
          w_gnt_nxt   = '0;
          w_state_nxt = S_RELEASE;
        end
      end
      default: begin
        // RELEASE re-arbitrates on its exit edge, giving the one-cycle grant gap
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
        if (|bus.REQ) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = NREQ'(1) << w_winner;
          w_hold_nxt  = '0;
          w_gidx_nxt  = w_winner;
`ifndef ARB_FIXED_PRIO_EN
          w_ptr_nxt   = w_winner;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_dout  <= '0;
      r_sel   <= 1'b0;
      r_hold  <= '0;
      r_ptr   <= c_PTR_RST;
      r_gidx  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_dout  <= w_dout_nxt;
      r_sel   <= w_sel_nxt;
      r_hold  <= w_hold_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gidx  <= w_gidx_nxt;
    end
  end

  assign bus.GNT    = r_gnt;
  assign bus.DOUT   = r_dout;
  assign bus.SELOUT = r_sel;
  assign bus.BUSY   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shared_dout_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_shared_dout_arbiter                                                   |
// | Directed and random stimulus against a behavioural model of the arbiter.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_shared_dout_arbiter;

  localparam int NREQ     = 4;
  localparam int DW       = 4;
  localparam int HOLD_MAX = 3;
  localparam int DINW     = NREQ * DW;
  localparam int MASK     = (1 << DW) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  shared_dout_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  shared_dout_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD_MAX(HOLD_MAX)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner index (-1 = none), loads done in this grant, release flag.
  int m_owner = -1;
  int m_loads = 0;
  int m_ptr   = NREQ - 1;
  int m_dout  = 0;
  bit m_sel   = 1'b0;
  bit m_rel   = 1'b0;

  function automatic int pick(input int rv, input int ptr);
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++)
      if (((rv >> k) & 1) != 0) return k;
`else
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (((rv >> idx) & 1) != 0) return idx;
    end
`endif
    return -1;
  endfunction

  always @(posedge CLK or negedge RST) begin : model
    int rv, dv, w;
    if (!RST) begin
      m_owner = -1; m_loads = 0; m_ptr = NREQ - 1;
      m_dout  = 0;  m_sel   = 1'b0; m_rel = 1'b0;
    end else begin
      rv = int'(bus.REQ);
      dv = int'(bus.DIN);
      if (m_owner >= 0) begin
        m_rel = 1'b1;
        if (((rv >> m_owner) & 1) != 0) begin
          m_dout = (dv >> (m_owner * DW)) & MASK;
          m_sel  = 1'b1;
          m_loads++;
          if (m_loads == HOLD_MAX) m_owner = -1;
        end else begin
          m_dout  = (m_dout + 1) & MASK;
          m_sel   = 1'b0;
          m_owner = -1;
        end
      end else begin
        m_dout = (m_dout + 1) & MASK;
        m_sel  = 1'b0;
        m_rel  = 1'b0;
        w = pick(rv, m_ptr);
        if (w >= 0) begin
          m_owner = w;
          m_loads = 0;
`ifndef ARB_FIXED_PRIO_EN
          m_ptr   = w;
`endif
        end
      end
    end
  end

  always @(negedge CLK) begin
    chk("gnt",    int'(bus.GNT),    (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("dout",   int'(bus.DOUT),   m_dout);
    chk("selout", int'(bus.SELOUT), int'(m_sel));
    chk("busy",   int'(bus.BUSY),   (m_owner >= 0 || m_rel) ? 1 : 0);
    chk("onehot", ($countones(bus.GNT) <= 1) ? 1 : 0, 1);
  end

  initial begin
    logic [NREQ-1:0] r;
    int exp_g;
    bus.REQ = '0;
    bus.DIN = '0;
    RST     = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_gnt",  int'(bus.GNT),    0);
    chk("rst_dout", int'(bus.DOUT),   0);
    chk("rst_sel",  int'(bus.SELOUT), 0);
    chk("rst_busy", int'(bus.BUSY),   0);
    RST = 1'b1;

    // free-running count with wrap
    for (int k = 0; k <= 16; k++) begin
      chk("count", int'(bus.DOUT), k % 16);
      @(negedge CLK);
    end

    // single request on requester 1
    bus.DIN = DINW'(32'h00A0);
    bus.REQ = 4'b0010;
    @(negedge CLK);
    chk("sr_gnt",  int'(bus.GNT),    2);
    chk("sr_busy", int'(bus.BUSY),   1);
    chk("sr_sel0", int'(bus.SELOUT), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("sr_dout", int'(bus.DOUT),   'hA);
      chk("sr_sel",  int'(bus.SELOUT), 1);
      chk("sr_gnt_hold", int'(bus.GNT), (k < 2) ? 2 : 0);
    end
    @(negedge CLK);
    chk("sr_regrant", int'(bus.GNT),    2);
    chk("sr_inc",     int'(bus.DOUT),   'hB);
    chk("sr_sel_off", int'(bus.SELOUT), 0);
    bus.REQ = '0;
    repeat (3) @(negedge CLK);

    // reset while requester 2 is mid-grant
    bus.DIN = DINW'(32'h0500);
    bus.REQ = 4'b0100;
    @(negedge CLK);
    chk("mg_gnt", int'(bus.GNT), 4);
    @(negedge CLK);
    chk("mg_sel",  int'(bus.SELOUT), 1);
    chk("mg_dout", int'(bus.DOUT),   5);
    #2 RST = 1'b0;
    #1;
    chk("mg_rst_gnt",  int'(bus.GNT),    0);
    chk("mg_rst_dout", int'(bus.DOUT),   0);
    chk("mg_rst_sel",  int'(bus.SELOUT), 0);
    chk("mg_rst_busy", int'(bus.BUSY),   0);
    bus.REQ = '0;
    @(negedge CLK);

    // all requesting: grant order after reset
    bus.DIN = DINW'(32'h4321);
    bus.REQ = 4'b1111;
    RST     = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge CLK);
      if (k % 4 == 1) begin
`ifdef ARB_FIXED_PRIO_EN
        exp_g = 1;
`else
        exp_g = 1 << ((k / 4) % 4);
`endif
        chk("rr_order", int'(bus.GNT), exp_g);
      end
      if (k == 2) chk("rr_first_load", int'(bus.DOUT), 1);
    end

    // early drop of requester 2 with requester 3 pending
    bus.REQ = '0;
    repeat (6) @(negedge CLK);
    bus.DIN = DINW'(32'h9700);
    bus.REQ = 4'b1100;
    @(negedge CLK);
    chk("ed_gnt", int'(bus.GNT), 4);
    @(negedge CLK);
    chk("ed_load", int'(bus.DOUT), 7);
    bus.REQ = 4'b1000;
    @(negedge CLK);
    chk("ed_inc",  int'(bus.DOUT),   8);
    chk("ed_sel",  int'(bus.SELOUT), 0);
    chk("ed_rel",  int'(bus.GNT),    0);
    chk("ed_busy", int'(bus.BUSY),   1);
    @(negedge CLK);
    chk("ed_next", int'(bus.GNT), 8);

    // random traffic: requests held until granted, sometimes dropped early
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      r = bus.REQ;
      for (int i = 0; i < NREQ; i++) begin
        if (((int'(r) >> i) & 1) != 0) begin
          if (m_owner == i && $urandom_range(0, 3) == 0) r = r ^ (NREQ'(1) << i);
        end else if ($urandom_range(0, 5) == 0) begin
          r = r | (NREQ'(1) << i);
        end
      end
      bus.REQ = r;
      bus.DIN = DINW'($urandom);
    end

    bus.REQ = '0;
    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
